mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port instruction/data BRAM between two requesters:
//  - CPU port: instruction fetch and LDRI/STRI accesses from the control FSM.
//  - Loader port: external program/debug loader.
//  Uses request/grant handshakes and fixed-latency read return.
//  Sits between the control FSM/PC/address mux and the BRAM.
// PARAMETERS
//  ADDR_W  8   BRAM address width
//  DATA_W  16  BRAM data width
//  RD_LAT  1   BRAM read latency in cycles, legal range 1..3
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  cpu_req     in   1       CPU access request; held until cpu_gnt
//  cpu_we      in   1       1 = write, 0 = read; valid with cpu_req
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       1-cycle pulse: CPU access issued to BRAM
//  cpu_rvalid  out  1       1-cycle pulse: cpu_rdata valid
//  cpu_rdata   out  DATA_W  CPU read data; held until next cpu_rvalid
//  ld_req/ld_we/ld_addr/ld_wdata/ld_gnt/ld_rvalid/ld_rdata
//              as the CPU port, for the loader
//  ld_hold     in   1       1 = CPU is never granted (program load)
//  mem_en      out  1       BRAM enable
//  mem_we      out  1       BRAM write enable
//  mem_addr    out  ADDR_W  BRAM address
//  mem_wdata   out  DATA_W  BRAM write data
//  mem_rdata   in   DATA_W  BRAM read data, RD_LAT cycles after mem_en
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: every output 0; FSM = IDLE; last_win = LOADER, so the CPU
//    wins the first tie.
//  - FSM: IDLE -> ISSUE -> (read: WAIT -> IDLE | write: IDLE).
//    - IDLE: samples requests. If any eligible, registers the winner's
//      we/addr/wdata onto mem_* and goes to ISSUE. Otherwise stays.
//    - ISSUE: exactly 1 cycle. mem_en=1 and the winner's gnt=1.
//      mem_we = winner's we. Updates last_win.
//    - WAIT: counts RD_LAT cycles after ISSUE. On the last count,
//      captures mem_rdata into the winner's rdata and pulses its rvalid
//      for 1 cycle, then goes to IDLE.
//  - Latency:
//    - req -> gnt: 1 cycle from IDLE.
//    - gnt -> rvalid: RD_LAT+1 cycles.
//    - Back-to-back writes: one every 2 cycles.
//    - Back-to-back reads: one every RD_LAT+2 cycles.
//  - Arbitration, evaluated in IDLE only:
//    - ld_hold=1: only ld_req is eligible; cpu_req waits, never dropped.
//    - Both eligible: grant the port that is not last_win (round-robin).
//    - Single requester: granted regardless of last_win.
//  - Handshake rules:
//    - req and payload must stay stable until gnt.
//    - Deasserting req before gnt withdraws it; no access is made.
//    - req held high after gnt is treated as a new request.
//  - Single outstanding access: no grant is issued in ISSUE or WAIT.
//  - mem_* are don't-care when mem_en=0, but are driven to 0.
//  - ld_hold changing mid-access does not affect the access in flight.
//  - rdata of the non-winning port is unchanged.
//  - Reset mid-access: in-flight read is dropped; no rvalid; rdata
//    cleared to 0.
// STRUCTURE
//  - Shared package cpu_mem_pkg:
//    - ADDR_W and DATA_W defaults
//    - state encoding IDLE/ISSUE/WAIT
//    - requester IDs REQ_CPU=0, REQ_LD=1
//  - Sub-module rr_arb2: combinational 2-way round-robin picker.
//    - Inputs: req[1:0], last_win, hold.
//    - Outputs: win_valid, win_id.
//  - Top level holds the FSM, latency counter, payload and rdata
//    registers.
// TESTING
//  1. Reset, then cpu_req read at addr 0x05 with BRAM[5]=0x1234
//     -> cpu_gnt 1 cycle later; cpu_rvalid with cpu_rdata=0x1234
//     RD_LAT+1 cycles after gnt.
//  2. cpu_req and ld_req both reads, held high from reset
//     -> grants alternate CPU, LD, CPU, LD; never two in a row to one
//     port.
//  3. ld_hold=1; loader writes 0xBEEF to 0x10 while cpu_req is pending
//     -> only ld_gnt. Drop ld_hold -> CPU granted; a read of 0x10
//     returns 0xBEEF.
//  4. CPU write 0x00AA to 0x3F, then immediately a read of 0x3F
//     -> gnts 2 cycles apart; rdata=0x00AA; mem_en high in exactly
//     2 cycles.
//  5. rst_n low during WAIT of a read
//     -> no rvalid; all outputs 0 at once; cpu_rdata=0; normal
//     operation after release.
//  6. cpu_req pulsed for 1 cycle while the arbiter is in WAIT
//     -> no cpu_gnt and no BRAM access for that pulse.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU/loader BRAM port arbiter.
package cpu_mem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The loader can lock the CPU out with hold.
module rr_arb2
   import cpu_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_win,
   input  logic       hold,
   output logic       win_valid,
   output logic       win_id
);

   logic [1:0] w_elig;

   // Eligible requests, then pick: single requester wins outright, a tie goes
   // to whichever port did not win last time.
   always_comb begin
      w_elig    = {req[REQ_LD], req[REQ_CPU] & ~hold};
      win_valid = |w_elig;
      win_id    = REQ_CPU;
      case (w_elig)
         2'b01:   win_id = REQ_CPU;
         2'b10:   win_id = REQ_LD;
         2'b11:   win_id = ~last_win;
         default: win_id = REQ_CPU;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port BRAM between the CPU and the external loader.
// One access in flight at a time; reads return after a fixed latency.
//
// state | meaning
// IDLE  | sampling requests; winner's payload registered on exit
// ISSUE | one cycle: mem_en high, winner's gnt pulses
// WAIT  | read only: counting down BRAM latency, returns data on last count
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   input  logic              ld_hold,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // Down-counter reload value: WAIT lasts RD_LAT cycles, terminal count 0.
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   state_t              r_state;
   state_t              w_next;
   logic                r_win_id;
   logic                r_last_win;
   logic [1:0]          r_lat_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_cpu_rvalid;
   logic                r_ld_rvalid;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_ld_rdata;

   logic                w_win_valid;
   logic                w_win_id;
   logic                w_rd_done;

   rr_arb2 u_arb (
      .req       ({ld_req, cpu_req}),
      .last_win  (r_last_win),
      .hold      (ld_hold),
      .win_valid (w_win_valid),
      .win_id    (w_win_id)
   );

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_win_valid) w_next = ISSUE;
         ISSUE:   w_next = r_we ? IDLE : WAIT;
         WAIT:    if (r_lat_cnt == 2'd0) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_rd_done = (r_state == WAIT) && (r_lat_cnt == 2'd0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Winner payload capture, round-robin history and latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_id   <= REQ_CPU;
         r_last_win <= REQ_LD;
         r_lat_cnt  <= 2'd0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         if (r_state == IDLE && w_win_valid) begin
            r_win_id <= w_win_id;
            r_we     <= (w_win_id == REQ_LD) ? ld_we    : cpu_we;
            r_addr   <= (w_win_id == REQ_LD) ? ld_addr  : cpu_addr;
            r_wdata  <= (w_win_id == REQ_LD) ? ld_wdata : cpu_wdata;
         end
         if (r_state == ISSUE) begin
            r_last_win <= r_win_id;
            r_lat_cnt  <= LAT_LAST;
         end else if (r_state == WAIT && r_lat_cnt != 2'd0) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
         end
      end
   end

   // Read return: only the winning port's rdata moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rvalid <= 1'b0;
         r_ld_rvalid  <= 1'b0;
         r_cpu_rdata  <= '0;
         r_ld_rdata   <= '0;
      end else begin
         r_cpu_rvalid <= w_rd_done && (r_win_id == REQ_CPU);
         r_ld_rvalid  <= w_rd_done && (r_win_id == REQ_LD);
         if (w_rd_done && r_win_id == REQ_CPU) r_cpu_rdata <= mem_rdata;
         if (w_rd_done && r_win_id == REQ_LD)  r_ld_rdata  <= mem_rdata;
      end
   end

   // BRAM side is zeroed whenever the enable is low.
   assign mem_en    = (r_state == ISSUE);
   assign mem_we    = mem_en & r_we;
   assign mem_addr  = mem_en ? r_addr  : '0;
   assign mem_wdata = mem_en ? r_wdata : '0;

   assign cpu_gnt    = mem_en && (r_win_id == REQ_CPU);
   assign ld_gnt     = mem_en && (r_win_id == REQ_LD);
   assign cpu_rvalid = r_cpu_rvalid;
   assign ld_rvalid  = r_ld_rvalid;
   assign cpu_rdata  = r_cpu_rdata;
   assign ld_rdata   = r_ld_rdata;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle BRAM model and a
// cycle-exact event scoreboard.
module tb_mem_port_arbiter;

   localparam int K_GNT = 0;
   localparam int K_RV  = 1;
   localparam int P_CPU = 0;
   localparam int P_LD  = 1;

   typedef struct {
      int          kind;
      int          port;
      int          cyc;
      logic        we;
      logic [7:0]  addr;
      logic [15:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [7:0]  cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic        ld_req = 1'b0, ld_we = 1'b0, ld_hold = 1'b0;
   logic [7:0]  ld_addr = '0;
   logic [15:0] ld_wdata = '0;
   logic        cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid;
   logic [15:0] cpu_rdata, ld_rdata;
   logic        mem_en, mem_we, busy;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;

   logic [15:0] bram [256];
   logic        bram_loaded = 1'b0;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] m_cpu_rdata = '0;
   logic [15:0] m_ld_rdata = '0;
   bit          stim_done = 1'b0;
   ev_t         sb_q[$];

   mem_port_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ld_req     (ld_req),
      .ld_we      (ld_we),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_gnt     (ld_gnt),
      .ld_rvalid  (ld_rvalid),
      .ld_rdata   (ld_rdata),
      .ld_hold    (ld_hold),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous BRAM, read latency 1; preloaded on the first edge.
   always @(posedge clk) begin
      if (!bram_loaded) begin
         foreach (bram[i]) bram[i] <= 16'h0000;
         bram[5] <= 16'h1234;
         bram[6] <= 16'h5678;
         bram_loaded <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) bram[mem_addr] <= mem_wdata;
         else        mem_rdata <= bram[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_gnt(input int port, input int c, input logic we,
                           input logic [7:0] addr, input logic [15:0] wdata);
      ev_t e;
      e.kind = K_GNT; e.port = port; e.cyc = c; e.we = we; e.addr = addr; e.data = wdata;
      sb_q.push_back(e);
   endtask

   task automatic push_rv(input int port, input int c, input logic [15:0] data);
      ev_t e;
      e.kind = K_RV; e.port = port; e.cyc = c; e.we = 1'b0; e.addr = 8'h00; e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic handle(input int kind, input int port);
      ev_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_event: kind %0d port %0d at cycle %0d, none expected",
                  kind, port, cyc);
         return;
      end
      e = sb_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_port", port, e.port);
      chk("event_cycle", cyc, e.cyc);
      if (kind == K_GNT) begin
         chk("gnt_mem_we", mem_we, e.we);
         chk("gnt_mem_addr", mem_addr, e.addr);
         chk("gnt_mem_wdata", mem_wdata, e.data);
         chk("gnt_busy", busy, 1);
      end else if (port == P_CPU) begin
         m_cpu_rdata = e.data;
      end else begin
         m_ld_rdata = e.data;
      end
   endtask

   task automatic mon_step();
      if (!rst_n) begin
         m_cpu_rdata = '0;
         m_ld_rdata  = '0;
         chk("reset_outputs",
             {cpu_gnt, cpu_rvalid, cpu_rdata, ld_gnt, ld_rvalid, ld_rdata,
              mem_en, mem_we, mem_addr, busy}, 64'h0);
         chk("reset_mem_wdata", mem_wdata, 0);
         return;
      end
      if (cpu_gnt)    handle(K_GNT, P_CPU);
      if (ld_gnt)     handle(K_GNT, P_LD);
      if (cpu_rvalid) handle(K_RV, P_CPU);
      if (ld_rvalid)  handle(K_RV, P_LD);
      chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
      chk("ld_rdata", ld_rdata, m_ld_rdata);
      if (!mem_en) chk("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_tests();
      int c;
      int en_cnt;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: single CPU read
      c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05; cpu_wdata = '0;
      push_gnt(P_CPU, c + 1, 1'b0, 8'h05, 16'h0);
      push_rv(P_CPU, c + 3, 16'h1234);
      wait_cyc(c + 2); cpu_req = 1'b0;
      wait_cyc(c + 5);

      // 2: both reading, held from reset -> strict alternation starting with CPU
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_addr = 8'h05;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h06; ld_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      c = cyc;
      push_gnt(P_CPU, c + 1,  1'b0, 8'h05, 16'h0); push_rv(P_CPU, c + 3,  16'h1234);
      push_gnt(P_LD,  c + 4,  1'b0, 8'h06, 16'h0); push_rv(P_LD,  c + 6,  16'h5678);
      push_gnt(P_CPU, c + 7,  1'b0, 8'h05, 16'h0); push_rv(P_CPU, c + 9,  16'h1234);
      push_gnt(P_LD,  c + 10, 1'b0, 8'h06, 16'h0); push_rv(P_LD,  c + 12, 16'h5678);
      wait_cyc(c + 11); cpu_req = 1'b0; ld_req = 1'b0;
      wait_cyc(c + 14);

      // 3: loader write under ld_hold while CPU read waits
      c = cyc;
      ld_hold = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = '0;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 16'hBEEF;
      push_gnt(P_LD, c + 1, 1'b1, 8'h10, 16'hBEEF);
      wait_cyc(c + 2); ld_req = 1'b0; ld_we = 1'b0; ld_wdata = '0;
      wait_cyc(c + 4); ld_hold = 1'b0;
      push_gnt(P_CPU, c + 5, 1'b0, 8'h10, 16'h0);
      push_rv(P_CPU, c + 7, 16'hBEEF);
      wait_cyc(c + 6); cpu_req = 1'b0;
      wait_cyc(c + 9);

      // 4: CPU write then immediate read of the same address
      c = cyc;
      en_cnt = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h3F; cpu_wdata = 16'h00AA;
      push_gnt(P_CPU, c + 1, 1'b1, 8'h3F, 16'h00AA);
      push_gnt(P_CPU, c + 3, 1'b0, 8'h3F, 16'h0);
      push_rv(P_CPU, c + 5, 16'h00AA);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         @(posedge clk);
         #1;
         if (k == 1) begin cpu_we = 1'b0; cpu_wdata = '0; end
         if (k == 3) cpu_req = 1'b0;
      end
      chk("mem_en_cycles", en_cnt, 2);

      // 5: reset during WAIT drops the read and clears rdata
      c = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
      push_gnt(P_CPU, c + 1, 1'b0, 8'h05, 16'h0);
      wait_cyc(c + 2); rst_n = 1'b0; cpu_req = 1'b0;
      wait_cyc(c + 4); rst_n = 1'b1;
      c = cyc;
      cpu_req = 1'b1; cpu_addr = 8'h3F;
      push_gnt(P_CPU, c + 1, 1'b0, 8'h3F, 16'h0);
      push_rv(P_CPU, c + 3, 16'h00AA);
      wait_cyc(c + 2); cpu_req = 1'b0;
      wait_cyc(c + 5);

      // 6: one-cycle CPU pulse during WAIT is never seen
      c = cyc;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h06;
      push_gnt(P_LD, c + 1, 1'b0, 8'h06, 16'h0);
      push_rv(P_LD, c + 3, 16'h5678);
      wait_cyc(c + 2); ld_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
      wait_cyc(c + 3); cpu_req = 1'b0;
      wait_cyc(c + 8);
   endtask

   initial begin
      fork
         begin
            while (!stim_done) begin
               @(negedge clk);
               if (!stim_done) mon_step();
            end
         end
         begin
            run_tests();
            stim_done = 1'b1;
         end
      join
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
